// File: rtl/gf2m_mul_pkg.sv
// Shared types and constants for the digit-serial GF(2^M) multiplier.
package gf2m_mul_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // x^163 + x^7 + x^6 + x^3 + 1 with the leading x^163 term implicit
    localparam logic [162:0] G163 = 163'hC9;

    // Number of D-bit digits needed to carry an M-bit operand
    function automatic int ndig(input int m, input int d);
        return (m + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One CALC cycle of the MSB-first interleaved multiplier: D unrolled
// shift / reduce / accumulate steps on an M-bit partial product.
module gf2m_digit_step
    import gf2m_mul_pkg::*;
#(
    parameter int M = 163,
    parameter int D = 8
) (
    input  logic [M-1:0] c,
    input  logic [M-1:0] a,
    input  logic [M-1:0] g,
    input  logic [D-1:0] b_digit,
    output logic [M-1:0] c_next
);

    logic [M-1:0] acc;

    // Multiply by x and fold the x^M overflow back through g, then add A
    // for each set bit of the digit, most significant bit first.
    always_comb begin
        acc = c;
        for (int k = D - 1; k >= 0; k--) begin
            acc = {acc[M-2:0], 1'b0} ^ ({M{acc[M-1]}} & g);
            if (b_digit[k]) begin
                acc = acc ^ a;
            end
        end
        c_next = acc;
    end

endmodule

// File: rtl/gf2m_digit_serial_mul.sv
// Digit-serial GF(2^M) multiplier: loads A, B and g as D-bit digits,
// multiplies in NDIG cycles and streams the product out MSD first.
module gf2m_digit_serial_mul
    import gf2m_mul_pkg::*;
#(
    parameter int M = 163,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] a_in,
    input  logic [D-1:0] b_in,
    input  logic [D-1:0] g_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [D-1:0] p_out,
    output logic         out_last,
    output logic         busy
);

    localparam int NDIG = ndig(M, D);
    localparam int W    = NDIG * D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_last;

    // A and G only ever need their low M bits; truncating the shift keeps
    // exactly the bits that survive padding removal.
    logic [M-1:0]  a_r;
    logic [M-1:0]  g_r;
    logic [W-1:0]  b_sr;
    logic [M-1:0]  c;
    logic [M-1:0]  c_next;
    logic [W-1:0]  out_sr;

    logic          in_fire;
    logic          out_fire;
    logic [M-1:0]  a_shift;
    logic [M-1:0]  g_shift;
    logic [W-1:0]  b_shift;

    assign cnt_last = (cnt == LAST_CNT);
    assign in_fire  = in_valid && (state == LOAD);
    assign out_fire = out_ready && (state == OUT);
    assign a_shift  = M'({a_r, a_in});
    assign g_shift  = M'({g_r, g_in});
    assign b_shift  = W'({b_sr, b_in});

    gf2m_digit_step #(
        .M (M),
        .D (D)
    ) u_step (
        .c       (c),
        .a       (a_r),
        .g       (g_r),
        .b_digit (b_sr[W-1 -: D]),
        .c_next  (c_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; clr overrides every transition
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_fire && cnt_last) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt_last) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                out_last  = cnt_last;
                if (out_fire && cnt_last) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
        if (clr) begin
            state_nxt = LOAD;
        end
    end

    assign p_out = out_sr[W-1 -: D];

    // Digit counter, operand shift registers, accumulator and output shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_r    <= '0;
            g_r    <= '0;
            b_sr   <= '0;
            c      <= '0;
            out_sr <= '0;
        end else if (clr) begin
            cnt    <= '0;
            a_r    <= '0;
            g_r    <= '0;
            b_sr   <= '0;
            c      <= '0;
            out_sr <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        a_r <= a_shift;
                        g_r <= g_shift;
                        if (cnt_last) begin
                            cnt  <= '0;
                            c    <= '0;
                            // B digits are consumed whole, so its padding is cleared here
                            b_sr <= W'(b_shift[M-1:0]);
                        end else begin
                            cnt  <= cnt + 1'b1;
                            b_sr <= b_shift;
                        end
                    end
                end
                CALC: begin
                    c    <= c_next;
                    b_sr <= W'({b_sr, {D{1'b0}}});
                    if (cnt_last) begin
                        cnt    <= '0;
                        out_sr <= W'(c_next);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        out_sr <= W'({out_sr, {D{1'b0}}});
                        cnt    <= cnt_last ? '0 : cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_digit_serial_mul.sv
// Scoreboard bench for gf2m_digit_serial_mul (M=163/D=8 plus a small M=8/D=3 instance).
module tb_gf2m_digit_serial_mul;
    import gf2m_mul_pkg::*;

    localparam int M  = 163;
    localparam int D  = 8;
    localparam int ND = 21;
    localparam int W  = 168;

    typedef struct packed { logic [7:0] d; logic last; } exp_t;
    typedef struct packed { logic [2:0] d; logic last; } exps_t;

    logic clk = 1'b0;
    logic rst, clr, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [7:0] a_in, b_in, g_in, p_out;

    logic s_clr, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy;
    logic [2:0] s_a_in, s_b_in, s_g_in, s_p_out;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   mode = 0;
    int   bp_beats = 0;
    int   bp_wait = 0;
    int   s_beat_edge = 0;
    exp_t  exp_q[$];
    exps_t exp_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf2m_digit_serial_mul #(.M(M), .D(D)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .g_in(g_in), .out_valid(out_valid),
        .out_ready(out_ready), .p_out(p_out), .out_last(out_last), .busy(busy)
    );

    gf2m_digit_serial_mul #(.M(8), .D(3)) dut_s (
        .clk(clk), .rst(rst), .clr(s_clr), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a_in(s_a_in), .b_in(s_b_in), .g_in(s_g_in), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .p_out(s_p_out), .out_last(s_out_last), .busy(s_busy)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Schoolbook polynomial product followed by long division by x^m + g
    function automatic logic [511:0] gf_mul(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] g, input int m);
        logic [511:0]  mask;
        logic [1023:0] prod;
        logic [1023:0] poly;
        mask = (512'd1 << m) - 512'd1;
        a    = a & mask;
        b    = b & mask;
        prod = '0;
        for (int i = 0; i < m; i++)
            if (b[i]) prod = prod ^ ({512'd0, a} << i);
        poly = {512'd0, g & mask} | (1024'd1 << m);
        for (int i = 2 * m - 2; i >= m; i--)
            if (prod[i]) prod = prod ^ (poly << (i - m));
        return prod[511:0];
    endfunction

    function automatic logic [167:0] rnd168();
        logic [167:0] r = '0;
        for (int i = 0; i < 6; i++) r = {r[135:0], 32'($urandom())};
        return r;
    endfunction

    task automatic push_expected(input logic [167:0] a, input logic [167:0] b, input logic [167:0] g);
        logic [511:0] r;
        logic [167:0] pw;
        r  = gf_mul({344'd0, a}, {344'd0, b}, {344'd0, g}, M);
        pw = {5'd0, r[162:0]};
        for (int d = 0; d < ND; d++) exp_q.push_back('{pw[167 - 8 * d -: 8], d == ND - 1});
    endtask

    task automatic send_job(input logic [167:0] a, input logic [167:0] b, input logic [167:0] g,
                            input int gap_pct, input bit push);
        int d = 0;
        int n = 0;
        while (d < ND) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                n_chk++; n_fail++;
                $display("FAIL load_timeout: got %0d beats accepted, required %0d", d, ND);
                in_valid = 1'b0;
                return;
            end
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                a_in = a[167 - 8 * d -: 8];
                b_in = b[167 - 8 * d -: 8];
                g_in = g[167 - 8 * d -: 8];
                if (in_ready) begin
                    d++;
                    if (d == ND && push) push_expected(a, b, g);
                end
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: got %0d digits outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic small_test();
        logic [8:0] a9 = 9'h157;
        logic [8:0] b9 = 9'h083;
        logic [8:0] g9 = 9'h01B;
        int d = 0;
        int n = 0;
        exp_s.push_back('{3'b011, 1'b0});
        exp_s.push_back('{3'b000, 1'b0});
        exp_s.push_back('{3'b001, 1'b1});
        while (d < 3 && n < 100) begin
            @(negedge clk);
            n++;
            s_in_valid = 1'b1;
            s_a_in = a9[8 - 3 * d -: 3];
            s_b_in = b9[8 - 3 * d -: 3];
            s_g_in = g9[8 - 3 * d -: 3];
            if (s_in_ready) begin
                if (d == 2) s_beat_edge = cyc + 1;
                d++;
            end
        end
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        n = 0;
        while ((exp_s.size() != 0 || s_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_chk++; n_fail++;
            $display("FAIL small_timeout: got %0d digits outstanding, required 0", exp_s.size());
        end
    endtask

    task automatic rst_pulse_in_out();
        int n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached OUT before rst", out_valid, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("out_valid on async rst", out_valid, 1'b0);
        chk("in_ready on async rst", in_ready, 1'b1);
        chk("busy on async rst", busy, 1'b0);
        chk("p_out on async rst", p_out, 8'h00);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    // Main scoreboard monitor: drives out_ready, pops and compares on each handshake
    logic       hold_v = 1'b0;
    logic       hold_l = 1'b0;
    logic [7:0] hold_p = '0;
    logic       after_last = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v     = 1'b0;
            after_last = 1'b0;
            out_ready  = 1'b1;
        end else begin
            if (hold_v && out_valid) begin
                chk("p_out stable under stall", p_out, hold_p);
                chk("out_last stable under stall", out_last, hold_l);
            end
            if (after_last) begin
                chk("in_ready after final beat", in_ready, 1'b1);
                chk("out_valid after final beat", out_valid, 1'b0);
            end
            hold_v     = 1'b0;
            after_last = 1'b0;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(7) != 0);
                default: begin
                    if (bp_beats == 4 && bp_wait < 5) begin
                        out_ready = 1'b0;
                        bp_wait++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_valid) begin
                chk("in_ready low in OUT", in_ready, 1'b0);
                chk("busy high in OUT", busy, 1'b1);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_digit: got %02h, required no output", p_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("p_out digit", p_out, e.d);
                        chk("out_last", out_last, e.last);
                        after_last = e.last;
                    end
                    bp_beats++;
                end else begin
                    hold_v = 1'b1;
                    hold_p = p_out;
                    hold_l = out_last;
                end
            end
        end
    end

    // Small-instance monitor: latency of first digit and digit values
    logic s_prev_valid = 1'b0;
    always @(negedge clk) begin
        exps_t e;
        if (rst) begin
            s_prev_valid = 1'b0;
        end else begin
            if (s_out_valid && !s_prev_valid) chk("small latency", cyc - s_beat_edge, 3);
            s_prev_valid = s_out_valid;
            if (s_out_valid) begin
                if (exp_s.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL small_unexpected: got %0h, required no output", s_p_out);
                end else begin
                    e = exp_s.pop_front();
                    chk("small p_out", s_p_out, e.d);
                    chk("small out_last", s_out_last, e.last);
                end
            end
        end
    end

    initial begin
        logic [167:0] gw;
        gw = {5'd0, G163};
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; g_in = '0;
        s_clr = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        s_a_in = '0; s_b_in = '0; s_g_in = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_last", out_last, 1'b0);
        chk("reset p_out", p_out, 8'h00);
        chk("reset busy", busy, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;

        // A = 1, B = 1 and A = x^162, B = x
        mode = 0;
        send_job(168'd1, 168'd1, gw, 0, 1'b1);
        drain();
        send_job(168'd1 << 162, 168'd2, gw, 0, 1'b1);
        drain();

        small_test();

        // Output stall after the fourth digit
        mode = 2; bp_beats = 0; bp_wait = 0;
        send_job(rnd168(), rnd168(), gw, 0, 1'b1);
        drain();
        chk("stall cycles applied", bp_wait, 5);
        mode = 0;

        // Abort in CALC, then a zero-operand job
        send_job(rnd168(), rnd168(), gw, 0, 1'b0);
        repeat (9) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("busy after clr", busy, 1'b0);
        chk("in_ready after clr", in_ready, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("no output after clr", out_valid, 1'b0);
        end
        send_job(168'd0, rnd168(), gw, 0, 1'b1);
        drain();

        // Random jobs with input gaps and output stalls
        mode = 1;
        for (int i = 0; i < 1000; i++) begin
            send_job(rnd168(), rnd168(), gw, 12, 1'b1);
            if (i == 500) rst_pulse_in_out();
        end
        drain();
        mode = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
